ram_sp_arb2: RTL and testbench

- Two-requester front-end that feeds one single-port synchronous RAM (1-cycle registered read; on a write, q returns the written data).
- Arbitrates two valid/ready request channels round-robin and issues at most one access per cycle to the RAM port signals (w, a, d).
- Steers the read data returned one cycle later back to the requester that issued the read, with a per-port response valid.
- Sits directly upstream of the single-port RAM, between it and two system-side masters.

---
 rtl/ram_sp_arb2.sv | 96 +++++++++
 tb/tb_ram_sp_arb2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arb2.sv
// ram_sp_arb2: two-port valid/ready front-end for one single-port synchronous RAM.
// Round-robin arbitration with combinational pass-through to the RAM port.
// Read data returns one cycle later and is steered to the port that issued the read.
module ram_sp_arb2 #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_v,
  input  logic          req0_rnw,
  input  logic [AW-1:0] req0_a,
  input  logic [DW-1:0] req0_d,
  output logic          req0_rdy,
  output logic          rsp0_v,
  output logic [DW-1:0] rsp0_d,
  input  logic          req1_v,
  input  logic          req1_rnw,
  input  logic [AW-1:0] req1_a,
  input  logic [DW-1:0] req1_d,
  output logic          req1_rdy,
  output logic          rsp1_v,
  output logic [DW-1:0] rsp1_d,
  output logic          ram_w,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  logic r_prio;
  logic r_rd_pend;
  logic r_rd_port;

  logic w_gnt_v;
  logic w_gnt_port;
  logic w_gnt_rnw;
  logic w_both;

  assign w_both = req0_v && req1_v;

  // Grant selection: a lone requester wins outright; under contention the
  // priority pointer decides. Nothing is granted while in reset.
  always_comb begin
    w_gnt_v    = 1'b0;
    w_gnt_port = 1'b0;
    if (!rst) begin
      if (w_both) begin
        w_gnt_v    = 1'b1;
        w_gnt_port = r_prio;
      end else if (req0_v) begin
        w_gnt_v    = 1'b1;
        w_gnt_port = 1'b0;
      end else if (req1_v) begin
        w_gnt_v    = 1'b1;
        w_gnt_port = 1'b1;
      end
    end
  end

  // RAM port driven straight from the granted master. Address/data follow
  // port 0 when idle; only ram_w has to be clean when nothing is granted.
  always_comb begin
    w_gnt_rnw = w_gnt_port ? req1_rnw : req0_rnw;
    ram_a     = w_gnt_port ? req1_a   : req0_a;
    ram_d     = w_gnt_port ? req1_d   : req0_d;
    ram_w     = w_gnt_v && !w_gnt_rnw;
    req0_rdy  = w_gnt_v && !w_gnt_port;
    req1_rdy  = w_gnt_v &&  w_gnt_port;
  end

  // Priority pointer flips to the loser only on contention; read tag
  // remembers who is owed the data coming out of the RAM next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio    <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_port <= 1'b0;
    end else begin
      if (w_both) begin
        r_prio <= ~w_gnt_port;
      end
      r_rd_pend <= w_gnt_v && w_gnt_rnw;
      r_rd_port <= w_gnt_port;
    end
  end

  // Responses: rd_pend may still be set in the first reset cycle, so the
  // valids are also gated by rst. Data is broadcast unqualified.
  always_comb begin
    rsp0_v = r_rd_pend && !rst && !r_rd_port;
    rsp1_v = r_rd_pend && !rst &&  r_rd_port;
    rsp0_d = ram_q;
    rsp1_d = ram_q;
  end

endmodule

// File: tb/tb_ram_sp_arb2.sv
// Directed bench for ram_sp_arb2 with a behavioural single-port RAM attached.
module tb_ram_sp_arb2;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_v, req0_rnw, req0_rdy, rsp0_v;
  logic [AW-1:0] req0_a;
  logic [DW-1:0] req0_d, rsp0_d;
  logic          req1_v, req1_rnw, req1_rdy, rsp1_v;
  logic [AW-1:0] req1_a;
  logic [DW-1:0] req1_d, rsp1_d;
  logic          ram_w;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Single-port RAM: registered read, write-first on q.
  always @(posedge clk) begin
    if (ram_w) begin
      mem[ram_a] <= ram_d;
      ram_q      <= ram_d;
    end else begin
      ram_q      <= mem[ram_a];
    end
  end

  ram_sp_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_v(req0_v), .req0_rnw(req0_rnw), .req0_a(req0_a), .req0_d(req0_d),
    .req0_rdy(req0_rdy), .rsp0_v(rsp0_v), .rsp0_d(rsp0_d),
    .req1_v(req1_v), .req1_rnw(req1_rnw), .req1_a(req1_a), .req1_d(req1_d),
    .req1_rdy(req1_rdy), .rsp1_v(rsp1_v), .rsp1_d(rsp1_d),
    .ram_w(ram_w), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_v = v; req0_rnw = rnw; req0_a = a; req0_d = d;
  endtask

  task automatic drv1(input logic v, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_v = v; req1_rnw = rnw; req1_a = a; req1_d = d;
  endtask

  task automatic do_reset();
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    mem[3] = 16'h3333;

    // Reset values with requests asserted during reset
    tick();
    drv0(1'b1, 1'b0, 16'h0007, 16'h0007);
    drv1(1'b1, 1'b1, 16'h0008, 16'h0000);
    #1;
    chk("rst_rdy0", req0_rdy, 0);
    chk("rst_rdy1", req1_rdy, 0);
    chk("rst_ram_w", ram_w, 0);
    chk("rst_rsp0_v", rsp0_v, 0);
    chk("rst_rsp1_v", rsp1_v, 0);
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ram_w", ram_w, 0);

    // 1: write then read same address from port 0
    drv0(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    #1;
    chk("t1_wr_rdy0", req0_rdy, 1);
    chk("t1_wr_ram_w", ram_w, 1);
    chk("t1_wr_ram_a", ram_a, 16'h0010);
    chk("t1_wr_ram_d", ram_d, 16'hBEEF);
    chk("t1_post_rst_rsp0_v", rsp0_v, 0);
    tick();
    drv0(1'b1, 1'b1, 16'h0010, 16'h0000);
    #1;
    chk("t1_rd_rdy0", req0_rdy, 1);
    chk("t1_rd_ram_w", ram_w, 0);
    chk("t1_rd_rsp0_v", rsp0_v, 0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    #1;
    chk("t1_rsp0_v", rsp0_v, 1);
    chk("t1_rsp0_d", rsp0_d, 16'hBEEF);
    chk("t1_rsp1_v", rsp1_v, 0);

    // 2: both ports read continuously, grants alternate
    do_reset();
    drv0(1'b1, 1'b1, 16'h0001, 16'h0000);
    drv1(1'b1, 1'b1, 16'h0002, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", req0_rdy, (i % 2 == 0) ? 1 : 0);
      chk("t2_rdy1", req1_rdy, (i % 2 == 1) ? 1 : 0);
      if (i == 0) begin
        chk("t2_rsp0_v0", rsp0_v, 0);
        chk("t2_rsp1_v0", rsp1_v, 0);
      end else if (i % 2 == 1) begin
        chk("t2_rsp0_v", rsp0_v, 1);
        chk("t2_rsp1_v", rsp1_v, 0);
        chk("t2_rsp0_d", rsp0_d, 16'h1111);
      end else begin
        chk("t2_rsp1_v", rsp1_v, 1);
        chk("t2_rsp0_v", rsp0_v, 0);
        chk("t2_rsp1_d", rsp1_d, 16'h2222);
      end
      tick();
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    #1;
    chk("t2_last_rsp1_v", rsp1_v, 1);
    chk("t2_last_rsp1_d", rsp1_d, 16'h2222);
    tick();
    chk("t2_drain_rsp1_v", rsp1_v, 0);

    // 3: port 1 streams alone, prio stays with port 0
    do_reset();
    drv1(1'b1, 1'b1, 16'h0003, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_solo_rdy1", req1_rdy, 1);
      chk("t3_solo_rdy0", req0_rdy, 0);
      if (i > 0) begin
        chk("t3_rsp1_v", rsp1_v, 1);
        chk("t3_rsp1_d", rsp1_d, 16'h3333);
      end
      tick();
    end
    drv0(1'b1, 1'b1, 16'h0001, 16'h0000);
    #1;
    chk("t3_cont_rdy0", req0_rdy, 1);
    chk("t3_cont_rdy1", req1_rdy, 0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    #1;
    chk("t3_rsp0_v", rsp0_v, 1);
    chk("t3_rsp0_d", rsp0_d, 16'h1111);

    // 4: same-address write (p0) vs read (p1) in one cycle
    do_reset();
    drv0(1'b1, 1'b0, 16'h0005, 16'hA5A5);
    drv1(1'b1, 1'b1, 16'h0005, 16'h0000);
    #1;
    chk("t4_rdy0", req0_rdy, 1);
    chk("t4_rdy1", req1_rdy, 0);
    chk("t4_ram_w", ram_w, 1);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    #1;
    chk("t4_rdy1_next", req1_rdy, 1);
    chk("t4_ram_w_rd", ram_w, 0);
    chk("t4_ram_a_rd", ram_a, 16'h0005);
    tick();
    drv1(1'b0, 1'b0, '0, '0);
    #1;
    chk("t4_rsp1_v", rsp1_v, 1);
    chk("t4_rsp1_d", rsp1_d, 16'hA5A5);
    chk("t4_rsp0_v", rsp0_v, 0);

    // 5: reset right after a read issue; prio left at 1 by test 4
    tick();
    drv0(1'b1, 1'b1, 16'h0001, 16'h0000);
    #1;
    chk("t5_rdy0", req0_rdy, 1);
    tick();
    rst = 1'b1;
    drv1(1'b1, 1'b1, 16'h0002, 16'h0000);
    #1;
    chk("t5_rst1_rsp0_v", rsp0_v, 0);
    chk("t5_rst1_rdy0", req0_rdy, 0);
    chk("t5_rst1_rdy1", req1_rdy, 0);
    chk("t5_rst1_ram_w", ram_w, 0);
    tick();
    #1;
    chk("t5_rst2_rsp0_v", rsp0_v, 0);
    chk("t5_rst2_rdy0", req0_rdy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rel_rsp0_v", rsp0_v, 0);
    chk("t5_rel_rsp1_v", rsp1_v, 0);
    chk("t5_rel_rdy0", req0_rdy, 1);
    chk("t5_rel_rdy1", req1_rdy, 0);
    tick();
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);

    // 6: writes only from both ports; alternating grants from prio 0
    do_reset();
    begin
      int i0 = 0;
      int i1 = 0;
      for (int c = 0; c < 6; c++) begin
        drv0(i0 < 3, 1'b0, 16'h0020 + 16'(i0), 16'h3000 + 16'(i0));
        drv1(i1 < 3, 1'b0, 16'h0030 + 16'(i1), 16'h4000 + 16'(i1));
        #1;
        chk("t6_rsp0_v", rsp0_v, 0);
        chk("t6_rsp1_v", rsp1_v, 0);
        chk("t6_rdy0", req0_rdy, (c % 2 == 0) ? 1 : 0);
        chk("t6_ram_w", ram_w, 1);
        if (req0_v && req0_rdy) i0++;
        if (req1_v && req1_rdy) i1++;
        tick();
      end
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    #1;
    chk("t6_tail_rsp0_v", rsp0_v, 0);
    chk("t6_tail_rsp1_v", rsp1_v, 0);
    chk("t6_mem20", mem[16'h0020], 16'h3000);
    chk("t6_mem21", mem[16'h0021], 16'h3001);
    chk("t6_mem22", mem[16'h0022], 16'h3002);
    chk("t6_mem30", mem[16'h0030], 16'h4000);
    chk("t6_mem31", mem[16'h0031], 16'h4001);
    chk("t6_mem32", mem[16'h0032], 16'h4002);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
